fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction queue depth and the limit on in-flight fetches (legal values 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_resp_valid  input  1  returned instruction valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump target update from the execute stage.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-012 inst_valid  output  1  queue head valid toward decode.
REQ-013 inst_data  output  32  queue head instruction.
REQ-014 inst_pc  output  32  address of inst_data.
REQ-015 inst_ready  input  1  decode consumes the head this cycle.

Function
REQ-016 A request SHALL be accepted when imem_req_valid and imem_req_ready are both 1; fetch_pc SHALL then advance by 4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0).
REQ-017 imem_req_valid SHALL be 1 only when queue occupancy plus outstanding requests < DEPTH, and 0 in the cycle redirect_valid is 1.
REQ-018 imem_req_addr SHALL equal fetch_pc and stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 Each non-dropped response SHALL be written to the queue tail with its PC (tracked by a PC-tag FIFO or a response-PC counter); queue write SHALL never overflow, by REQ-017.
REQ-020 inst_valid SHALL be 1 whenever the queue is non-empty; head SHALL pop on inst_valid & inst_ready; push and pop in the same cycle SHALL keep occupancy unchanged; push into an empty queue SHALL appear on inst_valid in the following cycle (no bypass).
REQ-021 On redirect_valid=1: queue SHALL flush, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, all currently outstanding requests SHALL be counted into drop_cnt, any request/pop in that cycle SHALL be ignored.
REQ-022 While drop_cnt > 0, each response SHALL decrement drop_cnt and be discarded; a response arriving in the redirect cycle SHALL be discarded.
REQ-023 FSM states: RESET_WAIT (first cycle after reset release, no request), RUN (normal), FLUSH (drop_cnt > 0, requests allowed under REQ-017 counting dropped slots as outstanding); RESET_WAIT->RUN unconditionally; RUN->FLUSH on redirect with outstanding > 0; FLUSH->RUN when drop_cnt reaches 0; redirect in FLUSH SHALL add new outstanding to drop_cnt.
REQ-024 Back-to-back redirects SHALL each take effect; the last one SHALL determine fetch_pc.

Reset
REQ-025 While reset=0: fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=RESET_WAIT, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-026 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses after reset release with no request issued SHALL be ignored.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding, instruction width (32), and the NOP constant 32'h0000_0013.
REQ-028 The instruction/PC queue SHALL be one sub-module, fetch_queue (parameterised DEPTH, synchronous flush).

Verification
REQ-029 Reset, ready=1, 1-cycle memory: requests at 0x0,0x4,0x8; inst_pc sequence 0x0,0x4,0x8 with matching data.
REQ-030 inst_ready=0, DEPTH=2: after two responses, imem_req_valid=0 and stays 0 until one pop.
REQ-031 Two outstanding, redirect to 0x103: both responses dropped, next request address 0x100, first inst_pc 0x100.
REQ-032 fetch_pc=0xFFFF_FFFC accepted -> next imem_req_addr 0x0000_0000.
REQ-033 imem_req_ready=0 for 5 cycles: imem_req_addr constant, no duplicate fetch.
REQ-034 reset pulsed low with outstanding fetch: all outputs at REQ-025 values; post-release stray response not enqueued; first request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int unsigned c_inst_w = 32;
    localparam logic [c_inst_w-1:0] c_nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_FLUSH      = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction/PC queue with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [c_inst_w-1:0]          push_data,
    input  logic [31:0]                  push_pc,
    input  logic                         pop,
    output logic                         valid,
    output logic [c_inst_w-1:0]          head_data,
    output logic [31:0]                  head_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [c_inst_w-1:0] r_data [DEPTH];
    logic [31:0]         r_pc   [DEPTH];
    logic [c_ptr_w-1:0]  r_wr;
    logic [c_ptr_w-1:0]  r_rd;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_ptr_w-1:0]  w_wr_nxt;
    logic [c_ptr_w-1:0]  w_rd_nxt;
    logic                w_push;
    logic                w_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly
    assign w_wr_nxt = (r_wr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr + c_ptr_w'(1);
    assign w_rd_nxt = (r_rd == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd + c_ptr_w'(1);

    assign valid  = (r_count != '0);
    assign w_push = push && (r_count != c_cnt_w'(DEPTH));
    assign w_pop  = pop && valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= c_nop;
                r_pc[i]   <= '0;
            end
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= push_data;
                r_pc[r_wr]   <= push_pc;
                r_wr         <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = valid ? r_data[r_rd] : '0;
    assign head_pc   = valid ? r_pc[r_rd]   : '0;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with bounded in-flight requests and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [c_inst_w-1:0] imem_resp_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                inst_valid,
    output logic [c_inst_w-1:0] inst_data,
    output logic [31:0]         inst_pc,
    input  logic                inst_ready
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_resp_pc;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_cnt_w-1:0]  r_drop_cnt;
    logic [c_cnt_w-1:0]  w_out_nxt;
    logic [c_cnt_w-1:0]  w_drop_nxt;
    logic [c_cnt_w-1:0]  w_q_count;
    logic [c_cnt_w:0]    w_inflight;
    logic [31:0]         w_redirect_aligned;
    logic                w_accept;
    logic                w_resp;
    logic                w_drop;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_ok;

    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign w_unused_ok        = ^redirect_pc[1:0];

    // Dropped-but-pending responses still occupy a slot in the in-flight budget
    assign w_inflight     = {1'b0, w_q_count} + {1'b0, r_outstanding};
    assign imem_req_valid = (r_state != ST_RESET_WAIT) && !redirect_valid
                            && (w_inflight < (c_cnt_w + 1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are strays from before a reset
    assign w_resp = imem_resp_valid && (r_outstanding != '0);
    assign w_drop = redirect_valid || (r_drop_cnt != '0);
    assign w_push = w_resp && !w_drop;
    assign w_pop  = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        w_out_nxt   = r_outstanding;
        w_drop_nxt  = r_drop_cnt;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_out_nxt = w_out_nxt + c_cnt_w'(1);
        end
        if (w_resp) begin
            w_out_nxt = w_out_nxt - c_cnt_w'(1);
        end
        if (redirect_valid) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_resp && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - c_cnt_w'(1);
        end
        case (r_state)
            ST_RESET_WAIT: w_state_nxt = ST_RUN;
            ST_RUN:        if (redirect_valid && (w_drop_nxt != '0)) w_state_nxt = ST_FLUSH;
            ST_FLUSH:      if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
            default:       w_state_nxt = ST_RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RESET_WAIT;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_aligned;
                r_resp_pc  <= w_redirect_aligned;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)   r_resp_pc  <= r_resp_pc + 32'd4;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (imem_resp_data),
        .push_pc   (r_resp_pc),
        .pop       (w_pop),
        .valid     (inst_valid),
        .head_data (inst_data),
        .head_pc   (inst_pc),
        .count     (w_q_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a latency-configurable memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] target; logic [31:0] pc0; logic [31:0] pc1; } redir_vec_t;

    pend_t       pending[$];
    exp_t        sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] model_pc = RESET_PC;
    bit          first_cyc = 1'b1;
    bit          stray = 1'b0;
    bit          d_ready = 1'b1;
    bit          d_redirect = 1'b0;
    bit          d_inst_ready = 1'b1;
    logic [31:0] d_redirect_pc = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, model memory and queue
    task automatic cycle();
        bit    rv_exp;
        pend_t p;
        exp_t  e;
        @(negedge clk);
        imem_req_ready  = d_ready;
        redirect_valid  = d_redirect;
        redirect_pc     = d_redirect_pc;
        inst_ready      = d_inst_ready;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #1;
        rv_exp = !first_cyc && !d_redirect && ((sb.size() + pending.size()) < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, rv_exp});
        if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, sb.size() != 0});
        if (inst_valid && d_inst_ready && !d_redirect && sb.size() != 0) begin
            e = sb.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst_data", inst_data, e.data);
            pop_log.push_back(inst_pc);
        end
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            p = pending.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(p.addr);
            if (!p.stale && !d_redirect) begin
                e.pc   = p.addr;
                e.data = mem_data(p.addr);
                sb.push_back(e);
            end
        end else if (stray) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        if (d_redirect) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            sb.delete();
            acc_log.delete();
            pop_log.delete();
            model_pc = {d_redirect_pc[31:2], 2'b00};
        end else if (imem_req_valid && d_ready) begin
            acc_log.push_back(imem_req_addr);
            p.addr  = model_pc;
            p.due   = cyc + lat;
            p.stale = 1'b0;
            pending.push_back(p);
            model_pc = model_pc + 32'd4;
        end
        first_cyc = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #1;
        check("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst inst_data", inst_data, 32'd0);
        check("rst inst_pc", inst_pc, 32'd0);
        repeat (2) @(posedge clk);
        pending.delete();
        sb.delete();
        acc_log.delete();
        pop_log.delete();
        model_pc  = RESET_PC;
        first_cyc = 1'b1;
        #2;
        reset = 1'b1;
    endtask

    redir_vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
        vecs[3] = '{32'h8000_0005, 32'h8000_0004, 32'h8000_0008};

        // Streaming fetch from reset with a 1-cycle memory
        d_ready = 1'b1; d_inst_ready = 1'b1; lat = 1;
        do_reset();
        repeat (12) cycle();
        for (int i = 0; i < 3; i++) begin
            check("stream acc", qget(acc_log, i), RESET_PC + 32'(4 * i));
            check("stream pop", qget(pop_log, i), RESET_PC + 32'(4 * i));
        end

        // Redirect with two requests in flight, several targets
        for (int v = 0; v < 4; v++) begin
            lat = 3; d_inst_ready = 1'b1;
            do_reset();
            repeat (3) cycle();
            d_redirect = 1'b1; d_redirect_pc = vecs[v].target;
            cycle();
            d_redirect = 1'b0;
            repeat (12) cycle();
            check("redir acc0", qget(acc_log, 0), vecs[v].pc0);
            check("redir acc1", qget(acc_log, 1), vecs[v].pc1);
            check("redir pop0", qget(pop_log, 0), vecs[v].pc0);
            check("redir pop1", qget(pop_log, 1), vecs[v].pc1);
        end

        // Back-to-back redirects: the last target wins
        lat = 3;
        do_reset();
        repeat (3) cycle();
        d_redirect = 1'b1; d_redirect_pc = 32'h0000_0200;
        cycle();
        d_redirect_pc = 32'h0000_0300;
        cycle();
        d_redirect = 1'b0;
        repeat (12) cycle();
        check("b2b acc0", qget(acc_log, 0), 32'h0000_0300);
        check("b2b pop0", qget(pop_log, 0), 32'h0000_0300);

        // Decode stalled: queue fills and requests stop until one pop
        lat = 1; d_inst_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        check("full acc count", acc_log.size(), 32'd2);
        d_inst_ready = 1'b1;
        cycle();
        d_inst_ready = 1'b0;
        cycle();
        check("after pop acc count", acc_log.size(), 32'd3);
        check("after pop acc2", qget(acc_log, 2), RESET_PC + 32'd8);

        // Memory not ready: address holds, no duplicate fetch
        d_inst_ready = 1'b1; d_ready = 1'b0;
        do_reset();
        repeat (6) cycle();
        check("stall acc count", acc_log.size(), 32'd0);
        d_ready = 1'b1;
        repeat (4) cycle();
        check("stall acc0", qget(acc_log, 0), RESET_PC);
        check("stall acc1", qget(acc_log, 1), RESET_PC + 32'd4);

        // Reset mid-transaction followed by stray responses
        lat = 3;
        do_reset();
        repeat (3) cycle();
        do_reset();
        stray = 1'b1;
        repeat (2) cycle();
        stray = 1'b0;
        repeat (10) cycle();
        check("post-rst acc0", qget(acc_log, 0), RESET_PC);
        check("post-rst pop0", qget(pop_log, 0), RESET_PC);
        check("post-rst pop1", qget(pop_log, 1), RESET_PC + 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
